// File: rtl/pixel_writer_pkg.sv
// Shared GPU constants for the pixel output path.
// Holds the default screen geometry, the frame pixel count, the framebuffer address width,
// the RGB555 field layout, the pipeline stage payload types and the 5-to-8 bit colour
// expansion helper.
package pixel_writer_pkg;

    localparam int unsigned SCREEN_W_DEF  = 160;
    localparam int unsigned SCREEN_H_DEF  = 144;
    localparam int unsigned FRAME_PIXELS  = SCREEN_W_DEF * SCREEN_H_DEF;
    localparam int unsigned FB_ADDR_W     = 15;
    localparam int unsigned FB_DATA_W     = 24;

    // RGB555 layout: {unused, B[14:10], G[9:5], R[4:0]}
    localparam int unsigned RGB555_FIELD_W = 5;
    localparam int unsigned RGB555_R_LSB   = 0;
    localparam int unsigned RGB555_G_LSB   = 5;
    localparam int unsigned RGB555_B_LSB   = 10;

    // S1 payload: raw selected colour plus its framebuffer position.
    typedef struct packed {
        logic [15:0]          color;
        logic [FB_ADDR_W-1:0] addr;
        logic                 last;
    } s1_entry_t;

    // S2 payload: expanded colour ready for the framebuffer.
    typedef struct packed {
        logic [FB_DATA_W-1:0] data;
        logic [FB_ADDR_W-1:0] addr;
        logic                 last;
    } s2_entry_t;

    // Bit replication keeps full-scale at full-scale (0x1F -> 0xFF) and zero at zero.
    function automatic logic [7:0] expand5to8(input logic [4:0] x);
        return {x, x[4:2]};
    endfunction

endpackage

// File: rtl/rgb555_to_rgb888.sv
// Combinational RGB555 to RGB888 colour expansion.
// Ports:
//   color_i  RGB555 colour, bit 15 ignored
//   rgb_o    {R8, G8, B8}
module rgb555_to_rgb888
    import pixel_writer_pkg::*;
(
    input  logic [15:0]          color_i,
    output logic [FB_DATA_W-1:0] rgb_o
);

    logic [RGB555_FIELD_W-1:0] r5;
    logic [RGB555_FIELD_W-1:0] g5;
    logic [RGB555_FIELD_W-1:0] b5;
    logic                      unused_msb;

    assign r5         = color_i[RGB555_R_LSB +: RGB555_FIELD_W];
    assign g5         = color_i[RGB555_G_LSB +: RGB555_FIELD_W];
    assign b5         = color_i[RGB555_B_LSB +: RGB555_FIELD_W];
    assign unused_msb = color_i[15];

    assign rgb_o = {expand5to8(r5), expand5to8(g5), expand5to8(b5)};

endmodule

// File: rtl/pixel_writer.sv
// Pixel writer: takes mixed PPU pixels, looks up their colour, expands RGB555 to RGB888 and
// writes them to a linear framebuffer through a two-stage valid/ready pipeline.
// Ports:
//   I_CLK, I_RESET                      clock, synchronous active-high reset
//   I_PIX_VALID/O_PIX_READY             pixel handshake from the mixer
//   I_PIX_IS_SPR, I_PIX_PAL, I_PIX_IDX  pixel palette source, palette and colour index
//   I_FRAME_START                       restart the framebuffer address at 0
//   O_BGPAL_*/I_BGPAL_COLOR             background palette lookup (combinational return)
//   O_SPRPAL_*/I_SPRPAL_COLOR           sprite palette lookup (combinational return)
//   O_FB_WE/I_FB_READY                  framebuffer write handshake
//   O_FB_ADDR, O_FB_DATA                write address y*SCREEN_W+x and {R8,G8,B8}
//   O_FRAME_DONE                        pulse when the last pixel of a frame is written
module pixel_writer
    import pixel_writer_pkg::*;
#(
    parameter int unsigned SCREEN_W = SCREEN_W_DEF,
    parameter int unsigned SCREEN_H = SCREEN_H_DEF
) (
    input  logic                 I_CLK,
    input  logic                 I_RESET,
    input  logic                 I_PIX_VALID,
    output logic                 O_PIX_READY,
    input  logic                 I_PIX_IS_SPR,
    input  logic [2:0]           I_PIX_PAL,
    input  logic [1:0]           I_PIX_IDX,
    input  logic                 I_FRAME_START,
    output logic [2:0]           O_BGPAL_SEL,
    output logic [1:0]           O_BGPAL_INDEX,
    input  logic [15:0]          I_BGPAL_COLOR,
    output logic [2:0]           O_SPRPAL_SEL,
    output logic [1:0]           O_SPRPAL_INDEX,
    input  logic [15:0]          I_SPRPAL_COLOR,
    output logic                 O_FB_WE,
    input  logic                 I_FB_READY,
    output logic [FB_ADDR_W-1:0] O_FB_ADDR,
    output logic [FB_DATA_W-1:0] O_FB_DATA,
    output logic                 O_FRAME_DONE
);

    localparam logic [FB_ADDR_W-1:0] LAST_ADDR = FB_ADDR_W'(SCREEN_W * SCREEN_H - 1);

    s1_entry_t            s1_q, s1_d;
    s2_entry_t            s2_q, s2_d;
    logic                 s1_valid_q, s1_valid_d;
    logic                 s2_valid_q, s2_valid_d;
    logic [FB_ADDR_W-1:0] addr_cnt_q, addr_cnt_d;

    logic                 s2_ready;
    logic                 s1_move;
    logic                 pix_accept;
    logic [15:0]          sel_color;
    logic [FB_ADDR_W-1:0] addr_base;
    logic [FB_DATA_W-1:0] s1_rgb;

    // Both lookups see the same palette/index; the source flag only picks the returned colour.
    assign O_BGPAL_SEL    = I_PIX_PAL;
    assign O_BGPAL_INDEX  = I_PIX_IDX;
    assign O_SPRPAL_SEL   = I_PIX_PAL;
    assign O_SPRPAL_INDEX = I_PIX_IDX;
    assign sel_color      = I_PIX_IS_SPR ? I_SPRPAL_COLOR : I_BGPAL_COLOR;

    // Ready depends only on stage state and I_FB_READY, never on I_PIX_VALID.
    assign s2_ready    = ~s2_valid_q | I_FB_READY;
    assign s1_move     = s1_valid_q & s2_ready;
    assign O_PIX_READY = ~s1_valid_q | s1_move;
    assign pix_accept  = I_PIX_VALID & O_PIX_READY;

    // A frame start applies to the pixel accepted in the same cycle.
    assign addr_base = I_FRAME_START ? '0 : addr_cnt_q;

    rgb555_to_rgb888 u_rgb555_to_rgb888 (
        .color_i (s1_q.color),
        .rgb_o   (s1_rgb)
    );

    always_comb begin
        addr_cnt_d = addr_cnt_q;
        s1_d       = s1_q;
        s1_valid_d = s1_valid_q;
        s2_d       = s2_q;
        s2_valid_d = s2_valid_q;

        if (pix_accept) begin
            addr_cnt_d = (addr_base == LAST_ADDR) ? '0 : addr_base + FB_ADDR_W'(1);
        end else if (I_FRAME_START) begin
            addr_cnt_d = '0;
        end

        if (pix_accept) begin
            s1_valid_d = 1'b1;
            s1_d.color = sel_color;
            s1_d.addr  = addr_base;
            s1_d.last  = (addr_base == LAST_ADDR);
        end else if (s1_move) begin
            s1_valid_d = 1'b0;
        end

        // Payload only updates when a pixel moves in, so idle outputs keep the last write.
        if (s2_ready) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_d.data = s1_rgb;
                s2_d.addr = s1_q.addr;
                s2_d.last = s1_q.last;
            end
        end
    end

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            addr_cnt_q <= '0;
            s1_q       <= '0;
            s1_valid_q <= 1'b0;
            s2_q       <= '0;
            s2_valid_q <= 1'b0;
        end else begin
            addr_cnt_q <= addr_cnt_d;
            s1_q       <= s1_d;
            s1_valid_q <= s1_valid_d;
            s2_q       <= s2_d;
            s2_valid_q <= s2_valid_d;
        end
    end

    assign O_FB_WE      = s2_valid_q;
    assign O_FB_ADDR    = s2_q.addr;
    assign O_FB_DATA    = s2_q.data;
    assign O_FRAME_DONE = s2_valid_q & s2_q.last & I_FB_READY;

endmodule

// File: tb/tb_pixel_writer.sv
// Self-checking bench for pixel_writer: a queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_pixel_writer;

    localparam int FRAME = 160 * 144;

    logic        clk;
    logic        rst;
    logic        pix_valid;
    logic        pix_ready;
    logic        is_spr;
    logic [2:0]  pal;
    logic [1:0]  idx;
    logic        frame_start;
    logic [2:0]  bg_sel;
    logic [1:0]  bg_idx;
    logic [15:0] bg_color;
    logic [2:0]  spr_sel;
    logic [1:0]  spr_idx;
    logic [15:0] spr_color;
    logic        fb_we;
    logic        fb_ready;
    logic [14:0] fb_addr;
    logic [23:0] fb_data;
    logic        frame_done;

    pixel_writer dut (
        .I_CLK          (clk),
        .I_RESET        (rst),
        .I_PIX_VALID    (pix_valid),
        .O_PIX_READY    (pix_ready),
        .I_PIX_IS_SPR   (is_spr),
        .I_PIX_PAL      (pal),
        .I_PIX_IDX      (idx),
        .I_FRAME_START  (frame_start),
        .O_BGPAL_SEL    (bg_sel),
        .O_BGPAL_INDEX  (bg_idx),
        .I_BGPAL_COLOR  (bg_color),
        .O_SPRPAL_SEL   (spr_sel),
        .O_SPRPAL_INDEX (spr_idx),
        .I_SPRPAL_COLOR (spr_color),
        .O_FB_WE        (fb_we),
        .I_FB_READY     (fb_ready),
        .O_FB_ADDR      (fb_addr),
        .O_FB_DATA      (fb_data),
        .O_FRAME_DONE   (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int          addr;
        logic [23:0] data;
        int          acc;
    } item_t;

    typedef struct {
        int          addr;
        logic [23:0] data;
        bit          done;
    } wr_t;

    item_t pipe_q[$];
    wr_t   wr_log[$];
    int    model_cnt = 0;
    int    cyc = 0;
    bit    model_on = 0;
    int    act_done_count = 0;

    function automatic logic [7:0] x8(input int v);
        int r;
        r = v * 8 + v / 4;
        return r[7:0];
    endfunction

    function automatic logic [23:0] expect_rgb(input logic [15:0] c);
        int cv;
        cv = int'(c);
        return {x8(cv % 32), x8((cv / 32) % 32), x8((cv / 1024) % 32)};
    endfunction

    bit    m_ready, m_we, m_wr, m_done, m_acc;
    int    m_base;
    item_t m_item;
    wr_t   m_wr_ent;

    // Compare process: inputs are stable at the falling edge, so this also decides what the
    // coming rising edge does and advances the model accordingly.
    always @(negedge clk) begin
        if (model_on) begin
            // At most two pixels buffered; a full pipeline frees a slot only if the write drains.
            m_ready = (pipe_q.size() < 2) || (fb_ready == 1'b1);
            check("pix_ready", pix_ready, m_ready);
            check("bgpal_sel", bg_sel, pal);
            check("bgpal_index", bg_idx, idx);
            check("sprpal_sel", spr_sel, pal);
            check("sprpal_index", spr_idx, idx);
            m_we = (pipe_q.size() > 0) && (cyc - pipe_q[0].acc >= 2);
            check("fb_we", fb_we, m_we);
            m_wr   = m_we && (fb_ready == 1'b1);
            m_done = m_wr && (pipe_q[0].addr == FRAME - 1);
            check("frame_done", frame_done, m_done);
            if (frame_done === 1'b1) act_done_count++;
            if (m_we) begin
                check("fb_addr", fb_addr, pipe_q[0].addr);
                check("fb_data", fb_data, pipe_q[0].data);
            end
            if (m_wr) begin
                m_wr_ent.addr = int'(fb_addr);
                m_wr_ent.data = fb_data;
                m_wr_ent.done = frame_done;
                wr_log.push_back(m_wr_ent);
                void'(pipe_q.pop_front());
            end
            m_acc = pix_valid && m_ready;
            if (rst) begin
                pipe_q.delete();
                model_cnt = 0;
            end else if (m_acc) begin
                m_base      = frame_start ? 0 : model_cnt;
                m_item.addr = m_base;
                m_item.data = expect_rgb(is_spr ? spr_color : bg_color);
                m_item.acc  = cyc;
                pipe_q.push_back(m_item);
                model_cnt = (m_base + 1) % FRAME;
            end else if (frame_start) begin
                model_cnt = 0;
            end
        end else if (rst) begin
            model_on = 1;
            pipe_q.delete();
            model_cnt = 0;
        end
        cyc++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_pixel();
        is_spr    = 1'($urandom);
        pal       = 3'($urandom);
        idx       = 2'($urandom);
        bg_color  = 16'($urandom);
        spr_color = 16'($urandom);
    endtask

    task automatic drain();
        pix_valid   = 1'b0;
        frame_start = 1'b0;
        fb_ready    = 1'b1;
        repeat (4) tick();
        check("drain_idle", fb_we, 1'b0);
    endtask

    function automatic int log_addr(input int k);
        if (k < wr_log.size()) return wr_log[k].addr;
        return -1;
    endfunction

    logic [4:0] rdy_pat;
    int         bad_order;

    initial begin
        rst = 1'b1; pix_valid = 1'b0; frame_start = 1'b0; fb_ready = 1'b1;
        is_spr = 1'b0; pal = '0; idx = '0; bg_color = '0; spr_color = '0;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        check("rst_pix_ready", pix_ready, 1'b1);
        check("rst_fb_we", fb_we, 1'b0);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_fb_addr", fb_addr, 15'd0);
        check("rst_fb_data", fb_data, 24'd0);

        // BG palette 2 index 1, colour 0x072C -> {63,CE,08} at address 0 two cycles later
        pix_valid = 1'b1; is_spr = 1'b0; pal = 3'd2; idx = 2'd1;
        bg_color = 16'h072C; spr_color = 16'h1234;
        #1;
        check("lit_bgpal_sel", bg_sel, 3'd2);
        check("lit_bgpal_index", bg_idx, 2'd1);
        tick();
        pix_valid = 1'b0;
        check("lit_lat1_we", fb_we, 1'b0);
        tick();
        check("lit_bg_we", fb_we, 1'b1);
        check("lit_bg_data", fb_data, 24'h63CE08);
        check("lit_bg_addr", fb_addr, 15'd0);

        // Sprite colour 0xFFFF -> white, bit 15 ignored, BG bus ignored
        pix_valid = 1'b1; is_spr = 1'b1; spr_color = 16'hFFFF; bg_color = 16'h0000;
        tick();
        pix_valid = 1'b0;
        tick();
        check("lit_spr_data", fb_data, 24'hFFFFFF);
        check("lit_spr_addr", fb_addr, 15'd1);
        drain();

        // Five-cycle stall with a continuous pixel offer
        wr_log.delete();
        fb_ready = 1'b0; pix_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rand_pixel();
            #1;
            rdy_pat[i] = pix_ready;
            if (i == 4) begin
                check("lit_stall_we", fb_we, 1'b1);
                check("lit_stall_addr", fb_addr, 15'd2);
            end
            tick();
        end
        check("lit_stall_ready_pattern", rdy_pat, 5'b00011);
        drain();
        check("lit_stall_count", wr_log.size(), 2);
        check("lit_stall_first", log_addr(0), 2);
        check("lit_stall_second", log_addr(1), 3);

        // Randomized traffic with stalls and occasional frame restarts
        for (int i = 0; i < 3000; i++) begin
            rand_pixel();
            pix_valid   = ($urandom_range(0, 3) != 0);
            fb_ready    = ($urandom_range(0, 3) != 0);
            frame_start = ($urandom_range(0, 199) == 0);
            tick();
        end
        drain();

        // Frame restart coinciding with an accept at address 500
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        wr_log.delete();
        pix_valid = 1'b1;
        for (int i = 0; i < 502; i++) begin
            rand_pixel();
            frame_start = (i == 500);
            tick();
        end
        drain();
        check("lit_fs_499", log_addr(499), 499);
        check("lit_fs_restart", log_addr(500), 0);
        check("lit_fs_next", log_addr(501), 1);

        // Full frame back-to-back, plus one pixel of the next frame
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        wr_log.delete();
        act_done_count = 0;
        pix_valid = 1'b1;
        for (int i = 0; i < FRAME + 1; i++) begin
            rand_pixel();
            tick();
        end
        drain();
        check("lit_frame_count", wr_log.size(), FRAME + 1);
        bad_order = 0;
        for (int i = 0; i < FRAME && i < wr_log.size(); i++) begin
            if (wr_log[i].addr != i) bad_order++;
        end
        check("lit_frame_order_errors", bad_order, 0);
        check("lit_frame_done_once", act_done_count, 1);
        check("lit_frame_last_addr", log_addr(FRAME - 1), FRAME - 1);
        check("lit_frame_last_done", (wr_log.size() >= FRAME) ? wr_log[FRAME - 1].done : 1'b0,
              1'b1);
        check("lit_frame_wrap", log_addr(FRAME), 0);

        // Reset with both stages full and stalled
        fb_ready = 1'b0; pix_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_pixel();
            tick();
        end
        check("lit_full_stall_ready", pix_ready, 1'b0);
        rst = 1'b1; pix_valid = 1'b0;
        tick();
        check("lit_rst_we", fb_we, 1'b0);
        check("lit_rst_ready", pix_ready, 1'b1);
        rst = 1'b0; fb_ready = 1'b1;
        wr_log.delete();
        pix_valid = 1'b1;
        rand_pixel();
        tick();
        drain();
        check("lit_rst_count", wr_log.size(), 1);
        check("lit_rst_first_addr", log_addr(0), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
